// File: rtl/storage_pkg.sv
// Shared definitions for the storage controller: QSPI opcodes, flash-read FSM states, SCK counter width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package storage_pkg;

    // Fast-read opcodes: single-lane address (quad data out) and quad-lane address (quad I/O)
    localparam logic [7:0] QSPI_OP_READ_QUAD_OUT = 8'h6B;
    localparam logic [7:0] QSPI_OP_READ_QUAD_IO  = 8'hEB;

    // Width of the per-phase SCK counter; wide enough for the longest phase (address or dummy)
    localparam int SCK_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_DONE  = 3'd5
    } qspi_state_t;

endpackage

// File: rtl/qspi_read_engine.sv
// QSPI flash word-read engine: command, address, dummy and quad-data phases with SCK generation (STORAGE_QUAD_IO_EN selects 0xEB quad-I/O).
// Latency: (8 + addr SCK + dummy SCK + 8) * CLK_DIV + 1 clk from start to done; one setup clk keeps cs low before the first SCK.
// Backpressure: start is sampled only in IDLE; a running read cannot be stalled, only aborted by rst.
module qspi_read_engine
    import storage_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [21:0] addr,
    input  logic [3:0]  io_i,
    output logic [3:0]  io_o,
    output logic [3:0]  io_t,
    output logic        ck,
    output logic        cs,
    output logic        done,
    output logic [31:0] rd_dat
);

`ifdef STORAGE_QUAD_IO_EN
    localparam bit QUAD_IO = 1'b1;
`else
    localparam bit QUAD_IO = 1'b0;
`endif

    // Quad-I/O sends 24 address bits plus the 0x00 mode byte as 8 nibbles in one phase
    localparam logic [7:0] OPCODE    = QUAD_IO ? QSPI_OP_READ_QUAD_IO : QSPI_OP_READ_QUAD_OUT;
    localparam int         ADDR_SCK  = QUAD_IO ? 8 : 24;
    localparam int         DUMMY_SCK = QUAD_IO ? 4 : DUMMY_CYCLES;
    localparam int         HALF      = CLK_DIV / 2;
    localparam int         DIV_W     = $clog2(CLK_DIV + 1);

    qspi_state_t          state;
    logic [DIV_W-1:0]     div_cnt;
    logic [SCK_CNT_W-1:0] bit_cnt;
    logic [SCK_CNT_W-1:0] phase_last;
    logic [31:0]          tx_sh;
    logic [31:0]          rx_sh;
    logic                 quad_addr;
    logic                 sck_rise;
    logic                 sck_fall;

    // div_cnt runs 1..CLK_DIV per SCK period; it starts at 0 so the first low half is one clk longer
    assign sck_rise  = (div_cnt == DIV_W'(HALF));
    assign sck_fall  = (div_cnt == DIV_W'(CLK_DIV));
    assign quad_addr = QUAD_IO && (state == ST_ADDR);
    assign done      = (state == ST_DONE);
    assign rd_dat    = rx_sh;

    // Index of the final SCK of the current phase
    always_comb begin
        phase_last = '0;
        case (state)
            ST_CMD:   phase_last = SCK_CNT_W'(7);
            ST_ADDR:  phase_last = SCK_CNT_W'(ADDR_SCK - 1);
            ST_DUMMY: phase_last = SCK_CNT_W'(DUMMY_SCK - 1);
            ST_DATA:  phase_last = SCK_CNT_W'(7);
            default:  phase_last = '0;
        endcase
    end

    // Pin drive follows state and tx_sh, both of which only move on accept or falling SCK edges
    always_comb begin
        io_o = 4'h0;
        io_t = 4'hF;
        case (state)
            ST_CMD: begin
                io_o = {3'b000, tx_sh[31]};
                io_t = 4'b1110;
            end
            ST_ADDR: begin
                if (QUAD_IO) begin
                    io_o = tx_sh[31:28];
                    io_t = 4'h0;
                end else begin
                    io_o = {3'b000, tx_sh[31]};
                    io_t = 4'b1110;
                end
            end
            default: begin
                io_o = 4'h0;
                io_t = 4'hF;
            end
        endcase
    end

    // Phase sequencing, SCK generation, command/address shift-out and data shift-in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            ck      <= 1'b0;
            cs      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_CMD;
                        cs      <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        // Opcode followed by the byte address; CMD shifts the opcode out, leaving the address on top
                        tx_sh   <= {OPCODE, addr, 2'b00};
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    if (sck_rise) begin
                        ck      <= 1'b1;
                        div_cnt <= div_cnt + DIV_W'(1);
                        if (state == ST_DATA) begin
                            rx_sh <= {rx_sh[27:0], io_i};
                        end
                    end else if (sck_fall) begin
                        ck      <= 1'b0;
                        div_cnt <= DIV_W'(1);
                        tx_sh   <= quad_addr ? {tx_sh[27:0], 4'h0} : {tx_sh[30:0], 1'b0};
                        if (bit_cnt == phase_last) begin
                            bit_cnt <= '0;
                            case (state)
                                ST_CMD:   state <= ST_ADDR;
                                ST_ADDR:  state <= ST_DUMMY;
                                ST_DUMMY: state <= ST_DATA;
                                default: begin
                                    state <= ST_DONE;
                                    cs    <= 1'b1;
                                end
                            endcase
                        end else begin
                            bit_cnt <= bit_cnt + SCK_CNT_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/storage_ctrl.sv
// Storage controller: internal byte-enabled SRAM, QSPI flash word reads, programming passthrough (STORAGE_QUAD_IO_EN selects quad-I/O flash reads).
// Latency: SRAM read 1 clk; flash read (48 SCK) * CLK_DIV + 2 clk at defaults, 28 * CLK_DIV + 2 with quad-I/O.
// Backpressure: none; memory_access is level-sensitive and the requester drops it on out_valid; flash requests only start when the engine is idle.
module storage_ctrl
    import storage_pkg::*;
#(
    parameter int SRAM_WORDS   = 2048,
    parameter int CLK_DIV      = 2,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_access,
    input  logic        memory_is_writing,
    input  logic [31:0] addr,
    input  logic [31:0] d_in,
    input  logic [3:0]  mem_be,
    input  logic        set_programming_mode,
    input  logic        external_storage_access,
    input  logic [3:0]  external_qspi_io_i,
    input  logic [3:0]  programming_qspi_io_o,
    input  logic [3:0]  programming_qspi_io_t,
    input  logic        programming_qspi_ck_o,
    input  logic        programming_qspi_cs_o,
    output logic [31:0] d_out,
    output logic        out_valid,
    output logic [3:0]  external_qspi_io_o,
    output logic [3:0]  external_qspi_io_t,
    output logic        external_qspi_ck_o,
    output logic        external_qspi_cs_o,
    output logic [3:0]  programming_qspi_io_i
);

    localparam int IDX_W = $clog2(SRAM_WORDS);

    logic [31:0]      sram [SRAM_WORDS];
    logic [IDX_W-1:0] idx;
    logic             sram_wr;
    logic             sram_rd;
    logic             flash_rd;
    logic [3:0]       eng_io_o;
    logic [3:0]       eng_io_t;
    logic             eng_ck;
    logic             eng_cs;
    logic             eng_done;
    logic [31:0]      eng_dat;
    logic             unused_addr_hi;

    // Upper address bits beyond the SRAM index and flash word address are don't-care
    assign unused_addr_hi = ^addr[31:22];
    assign idx            = addr[IDX_W-1:0];

    assign sram_wr  = memory_access &  memory_is_writing & ~external_storage_access;
    assign sram_rd  = memory_access & ~memory_is_writing & ~external_storage_access;
    assign flash_rd = memory_access & ~memory_is_writing &  external_storage_access & ~set_programming_mode;

    qspi_read_engine #(
        .CLK_DIV      (CLK_DIV),
        .DUMMY_CYCLES (DUMMY_CYCLES)
    ) u_qspi_read_engine (
        .clk    (clk),
        .rst    (rst),
        .start  (flash_rd),
        .addr   (addr[21:0]),
        .io_i   (external_qspi_io_i),
        .io_o   (eng_io_o),
        .io_t   (eng_io_t),
        .ck     (eng_ck),
        .cs     (eng_cs),
        .done   (eng_done),
        .rd_dat (eng_dat)
    );

    // Programming mode hands the flash pins straight to the programmer, independent of clock and reset
    assign external_qspi_io_o    = set_programming_mode ? programming_qspi_io_o : eng_io_o;
    assign external_qspi_io_t    = set_programming_mode ? programming_qspi_io_t : eng_io_t;
    assign external_qspi_ck_o    = set_programming_mode ? programming_qspi_ck_o : eng_ck;
    assign external_qspi_cs_o    = set_programming_mode ? programming_qspi_cs_o : eng_cs;
    assign programming_qspi_io_i = external_qspi_io_i;

    // SRAM byte-enabled write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    sram[idx][8*b +: 8] <= d_in[8*b +: 8];
                end
            end
        end
    end

    // Read return: a completing flash read wins over a same-cycle SRAM read so the long transaction is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out     <= '0;
            out_valid <= 1'b0;
        end else if (eng_done) begin
            d_out     <= eng_dat;
            out_valid <= 1'b1;
        end else if (sram_rd) begin
            d_out     <= sram[idx];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_storage_ctrl.sv
// Self-checking bench for storage_ctrl: SRAM, flash reads against a QSPI flash model, programming passthrough, reset abort.
// Latency: flash reads expected (48 SCK) * CLK_DIV + 2 clk after the accept edge.
// Backpressure: requester drops memory_access on the cycle out_valid is seen.
module tb_storage_ctrl;

    localparam int SRAM_WORDS   = 2048;
    localparam int CLK_DIV      = 2;
    localparam int DUMMY_CYCLES = 8;
    localparam int FLASH_LAT    = (8 + 24 + DUMMY_CYCLES + 8) * CLK_DIV + 2;
    localparam int DATA_SCK0    = 8 + 24 + DUMMY_CYCLES;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memory_access;
    logic        memory_is_writing;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic [3:0]  mem_be;
    logic        set_programming_mode;
    logic        external_storage_access;
    logic [3:0]  external_qspi_io_i;
    logic [3:0]  programming_qspi_io_o;
    logic [3:0]  programming_qspi_io_t;
    logic        programming_qspi_ck_o;
    logic        programming_qspi_cs_o;
    logic [31:0] d_out;
    logic        out_valid;
    logic [3:0]  external_qspi_io_o;
    logic [3:0]  external_qspi_io_t;
    logic        external_qspi_ck_o;
    logic        external_qspi_cs_o;
    logic [3:0]  programming_qspi_io_i;

    logic [3:0]  flash_io = 4'h0;
    logic [3:0]  tb_io    = 4'h0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    assign external_qspi_io_i = set_programming_mode ? tb_io : flash_io;

    always #5 clk = ~clk;

    storage_ctrl #(
        .SRAM_WORDS   (SRAM_WORDS),
        .CLK_DIV      (CLK_DIV),
        .DUMMY_CYCLES (DUMMY_CYCLES)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .memory_access           (memory_access),
        .memory_is_writing       (memory_is_writing),
        .addr                    (addr),
        .d_in                    (d_in),
        .mem_be                  (mem_be),
        .set_programming_mode    (set_programming_mode),
        .external_storage_access (external_storage_access),
        .external_qspi_io_i      (external_qspi_io_i),
        .programming_qspi_io_o   (programming_qspi_io_o),
        .programming_qspi_io_t   (programming_qspi_io_t),
        .programming_qspi_ck_o   (programming_qspi_ck_o),
        .programming_qspi_cs_o   (programming_qspi_cs_o),
        .d_out                   (d_out),
        .out_valid               (out_valid),
        .external_qspi_io_o      (external_qspi_io_o),
        .external_qspi_io_t      (external_qspi_io_t),
        .external_qspi_ck_o      (external_qspi_ck_o),
        .external_qspi_cs_o      (external_qspi_cs_o),
        .programming_qspi_io_i   (programming_qspi_io_i)
    );

    // Flash contents: word at byte address 4a
    function automatic logic [31:0] fmem(input logic [21:0] a);
        return {8'h5A ^ a[7:0], a[15:8] ^ 8'h96, ~a[7:0], 8'hC3 + a[7:0]};
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flash model: decodes opcode/address on io0 at rising SCK, drives data nibbles after falling SCK
    int          sck_n = 0;
    logic [7:0]  f_op;
    logic [23:0] f_addr;
    logic [31:0] f_word;
    logic [31:0] f_tmp;

    always @(negedge external_qspi_cs_o) begin
        if (!set_programming_mode) sck_n = 0;
    end

    always @(posedge external_qspi_ck_o) begin
        if (!external_qspi_cs_o && !set_programming_mode) begin
            sck_n++;
            if (sck_n <= 8) f_op = {f_op[6:0], external_qspi_io_o[0]};
            else if (sck_n <= 32) f_addr = {f_addr[22:0], external_qspi_io_o[0]};
            if (sck_n == 32) f_word = fmem(f_addr[23:2]);
        end
    end

    always @(negedge external_qspi_ck_o) begin
        if (!external_qspi_cs_o && !set_programming_mode &&
            sck_n >= DATA_SCK0 && sck_n < DATA_SCK0 + 8) begin
            f_tmp    = f_word << (4 * (sck_n - DATA_SCK0));
            flash_io = f_tmp[31:28];
        end
    end

    // Scoreboard: every out_valid must match the oldest expected word
    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (!rst && out_valid) begin
            check32("valid_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check32("d_out", d_out, e);
            end
        end
    end

    task automatic flash_read(input logic [31:0] a);
        int   cyc;
        logic got;
        @(negedge clk);
        exp_q.push_back(fmem(a[21:0]));
        addr                    = a;
        external_storage_access = 1'b1;
        memory_is_writing       = 1'b0;
        memory_access           = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (out_valid) got = 1'b1;
        end
        memory_access = 1'b0;
        check32("flash_got_valid", 32'(got), 32'd1);
        if (got) begin
            check32("flash_latency", 32'(cyc - 1), 32'(FLASH_LAT));
            check32("flash_cs_high", 32'(external_qspi_cs_o), 32'd1);
            check32("flash_opcode", 32'(f_op), 32'h6B);
            check32("flash_addr", 32'(f_addr), 32'({a[21:0], 2'b00}));
        end
    endtask

    task automatic sram_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge clk);
        #1;
        addr                    = a;
        d_in                    = d;
        mem_be                  = be;
        memory_is_writing       = 1'b1;
        external_storage_access = 1'b0;
        memory_access           = 1'b1;
        @(posedge clk);
        #1;
        memory_access     = 1'b0;
        memory_is_writing = 1'b0;
    endtask

    task automatic sram_read(input logic [31:0] a, input logic [31:0] expv);
        @(posedge clk);
        #1;
        exp_q.push_back(expv);
        addr                    = a;
        memory_is_writing       = 1'b0;
        external_storage_access = 1'b0;
        memory_access           = 1'b1;
        @(posedge clk);
        #1;
        memory_access = 1'b0;
    endtask

    initial begin
        int wait_cyc;
        memory_access           = 1'b0;
        memory_is_writing       = 1'b0;
        addr                    = '0;
        d_in                    = '0;
        mem_be                  = 4'h0;
        set_programming_mode    = 1'b0;
        external_storage_access = 1'b0;
        programming_qspi_io_o   = 4'h0;
        programming_qspi_io_t   = 4'h0;
        programming_qspi_ck_o   = 1'b0;
        programming_qspi_cs_o   = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        check32("rst_d_out", d_out, 32'h0);
        check32("rst_out_valid", 32'(out_valid), 32'd0);
        check32("rst_pins", 32'({external_qspi_cs_o, external_qspi_ck_o, external_qspi_io_t, external_qspi_io_o}), 32'h2F0);

        // Passthrough works while still in reset
        set_programming_mode  = 1'b1;
        programming_qspi_cs_o = 1'b0;
        programming_qspi_ck_o = 1'b1;
        programming_qspi_io_t = 4'h5;
        programming_qspi_io_o = 4'hC;
        #1;
        check32("rst_passthru", 32'({external_qspi_cs_o, external_qspi_ck_o, external_qspi_io_t, external_qspi_io_o}), 32'h15C);
        set_programming_mode  = 1'b0;
        programming_qspi_cs_o = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Flash read sweep
        for (int a = 0; a < 'h50; a++) flash_read(32'(a));

        // Programming passthrough sweep
        @(negedge clk);
        set_programming_mode = 1'b1;
        for (int v = 0; v < 1024; v++) begin
            @(posedge clk);
            #1;
            {programming_qspi_cs_o, programming_qspi_ck_o, programming_qspi_io_t, programming_qspi_io_o} = 10'(v);
            @(negedge clk);
            check32("passthru", 32'({external_qspi_cs_o, external_qspi_ck_o, external_qspi_io_t, external_qspi_io_o}), 32'(v));
        end
        tb_io = 4'hA;
        #1;
        check32("prog_io_i", 32'(programming_qspi_io_i), 32'hA);

        // In programming mode flash reads are ignored but SRAM still serves
        @(negedge clk);
        addr                    = 32'h10;
        memory_is_writing       = 1'b0;
        external_storage_access = 1'b1;
        memory_access           = 1'b1;
        repeat (6) @(negedge clk);
        memory_access = 1'b0;
        sram_write(32'h7, 32'hCAFE0007, 4'hF);
        sram_read(32'h7, 32'hCAFE0007);
        @(negedge clk);
        set_programming_mode = 1'b0;
        #1;
        check32("prog_flash_ignored_cs", 32'(external_qspi_cs_o), 32'd1);

        // SRAM full-depth write then read
        for (int i = 0; i < SRAM_WORDS; i++) sram_write(32'(i), 32'(i), 4'hF);
        for (int i = 0; i < SRAM_WORDS; i++) sram_read(32'(i), 32'(i));

        // Address wrap and byte enables
        sram_write(32'h805, 32'hDEADBEEF, 4'hF);
        sram_read(32'h5, 32'hDEADBEEF);
        sram_write(32'h20, 32'hFFFFFFFF, 4'hF);
        sram_write(32'h20, 32'h12345678, 4'b0101);
        sram_read(32'h20, 32'hFF34FF78);

        // Reset in the middle of the data phase
        @(negedge clk);
        exp_q.push_back(fmem(22'h33));
        addr                    = 32'h33;
        memory_is_writing       = 1'b0;
        external_storage_access = 1'b1;
        memory_access           = 1'b1;
        wait_cyc = 0;
        while (sck_n != DATA_SCK0 + 3 && wait_cyc < 400) begin
            @(negedge clk);
            wait_cyc++;
        end
        check32("mid_read_reached", 32'(sck_n), 32'(DATA_SCK0 + 3));
        rst           = 1'b1;
        memory_access = 1'b0;
        #1;
        check32("mid_rst_pins", 32'({external_qspi_cs_o, external_qspi_ck_o, external_qspi_io_t, external_qspi_io_o}), 32'h2F0);
        check32("mid_rst_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        flash_read(32'h33);

        // Flash writes are ignored
        @(negedge clk);
        addr                    = 32'h5;
        d_in                    = 32'h55555555;
        mem_be                  = 4'hF;
        memory_is_writing       = 1'b1;
        external_storage_access = 1'b1;
        memory_access           = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check32("fwrite_cs", 32'(external_qspi_cs_o), 32'd1);
        end
        memory_access     = 1'b0;
        memory_is_writing = 1'b0;

        repeat (4) @(negedge clk);
        check32("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/storage_ctrl.md
Name: storage_ctrl

Overview:
- Memory-side storage controller for the core.
- Serves word reads and writes from an internal SRAM.
- Serves word reads from an external QSPI flash.
- A programming mode hands the flash QSPI pins straight through to a programming port for in-system flash programming.

Parameters:
- SRAM_WORDS, 2048: internal SRAM depth in 32-bit words. Index is addr[$clog2(SRAM_WORDS)-1:0]; upper bits are ignored, so addresses wrap.
- CLK_DIV, 2: clk cycles per QSPI SCK period. Must be even and ≥2.
- DUMMY_CYCLES, 8: dummy SCK cycles in a flash read.

Ports:
- clk in 1: system clock; all logic on rising edge.
- rst in 1: asynchronous, active-high reset.
- memory_access in 1: request valid, level-sensitive.
- memory_is_writing in 1: 1 = write, 0 = read.
- addr in 32: word address.
- d_in in 32: write data.
- mem_be in 4: byte enables; bit n enables d_in[8n+7:8n].
- set_programming_mode in 1: 1 = pass the programming QSPI port through to the flash.
- external_storage_access in 1: 1 = target the flash, 0 = target the SRAM.
- external_qspi_io_i in 4: flash IO input.
- programming_qspi_io_o in 4, programming_qspi_io_t in 4, programming_qspi_ck_o in 1, programming_qspi_cs_o in 1: programmer-driven pins.
- d_out out 32: read data.
- out_valid out 1: read data valid.
- external_qspi_io_o out 4, external_qspi_io_t out 4 (1 = tristate), external_qspi_ck_o out 1, external_qspi_cs_o out 1 (active low): flash pins.
- programming_qspi_io_i out 4: always equals external_qspi_io_i, combinationally.

Behaviour:
- Reset values:
  - d_out = 0, out_valid = 0.
  - FSM in IDLE.
  - Internal flash pins: cs = 1, ck = 0, io_o = 0, io_t = 4'hF.
  - SRAM contents are not reset.
- Programming mode (set_programming_mode = 1): flash outputs are combinational copies of the programming_qspi_* inputs, even during reset. Flash requests are ignored (no out_valid). SRAM accesses still work.
- SRAM write: at a rising edge with memory_access & memory_is_writing & !external_storage_access, write the enabled bytes. No out_valid.
- SRAM read: a rising edge with memory_access & !memory_is_writing & !external_storage_access registers d_out = sram[idx] and out_valid = 1. out_valid stays 1 (re-read every cycle) while the request is held and drops the cycle after it is removed.
- Flash writes (external & writing) are ignored.
- Flash read FSM, states IDLE → CMD → ADDR → DUMMY → DATA → DONE → IDLE:
  - IDLE: accepts a flash read only here. At the accept edge, latch addr and drive cs low.
  - CMD: opcode 0x6B, 8 SCK, on io0 MSB first. io_t = 4'b1110.
  - ADDR: 24-bit byte address = {addr[21:0], 2'b00}, 24 SCK, on io0 MSB first. io_t = 4'b1110.
  - DUMMY: DUMMY_CYCLES SCK, io_t = 4'hF.
  - DATA: 8 SCK, 4 bits each, first nibble → d_out[31:28]. io_t = 4'hF.
  - DONE: cs high, out_valid = 1 for exactly one cycle, d_out held until the next read completes.
- SPI timing: mode 0; SCK idles low; outputs change on the falling edge; io_i is sampled on the rising SCK edge.
- Latency: (8 + 24 + DUMMY_CYCLES + 8) × CLK_DIV + 2 clk from the accept edge to out_valid, i.e. 98 clk at the defaults.
- Switches on inputs are ignored mid-transaction. The transaction completes unless rst asserts; rst returns immediately to IDLE with reset pin values.
- A request held high through DONE starts a new read only once IDLE samples it again. The requester must drop memory_access on seeing out_valid.

Optional Feature:
- STORAGE_QUAD_IO_EN:
  - Defined: opcode 0xEB. The address is sent on all 4 IO lines (6 SCK, io_t = 0), followed by mode byte 0x00 (2 SCK, io_t = 0), then 4 dummy SCK (overrides DUMMY_CYCLES), then DATA as above. Latency = 28 × CLK_DIV + 2.
  - Undefined: 0x6B sequence as above.

Decomposition:
- Package storage_pkg: opcode constants QSPI_OP_READ_QUAD_OUT = 8'h6B and QSPI_OP_READ_QUAD_IO = 8'hEB, the FSM state enum, and the SCK counter width.
- Sub-module qspi_read_engine: FSM, SCK generation, shift registers.
- The top holds the SRAM, request decode and programming mux.

Test Plan:
- Flash read sweep: flash model word at byte address 4a holds mem[a]. Read addr 0..0x4F, external_storage_access = 1 → out_valid pulses once per read, d_out = mem[a], cs returns high between reads.
- Passthrough: set_programming_mode = 1, sweep {cs, ck, io_t, io_o} over all 1024 combinations of values 0..0x3FF → external outputs match on the following negedge. Drive io_i = 4'hA → programming_qspi_io_i = 4'hA.
- SRAM write/read: for i = 0..0x7FF write d_in = i with mem_be = 4'hF, then read i → d_out = i with out_valid.
- Byte enables: write 0xFFFFFFFF, then write 0x12345678 with be = 4'b0101 → read returns 0xFF34FF78.
- Reset mid-flash-read: assert rst at DATA nibble 3 → cs = 1, ck = 0, io_t = 4'hF, out_valid = 0. The next read returns correct data.
- Flash write attempt at addr 5 → no QSPI activity (cs stays 1), no out_valid.
